// File: rtl/ram_arb_pkg.sv
// ============================================================================
// ram_arb_pkg : shared types and helpers for the two-master RAM port arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } mst_id_e;

  typedef struct packed {
    logic    valid;
    mst_id_e id;
    logic    is_read;
    logic    err;
  } rsp_tag_t;

  function automatic int unsigned ram_depth(input int unsigned word_bytes,
                                            input int unsigned size_kb);
    return (size_kb * 1024) / word_bytes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arb_picker.sv
// ============================================================================
// ram_arb_picker : one-hot grant from two requests (round-robin when
// RAM_ARB_ROUND_ROBIN_EN is defined, fixed m0 priority otherwise)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arb_picker
  import ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  mst_id_e    ptr_i,
  output logic [1:0] gnt_o
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // ptr_i names the master that wins the next contention
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (ptr_i == MST_M0) ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr_i;

  always_comb begin
    gnt_o = {req_i[1] & ~req_i[0], req_i[0]};
  end
`endif

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// ram_port_arbiter : shares a single-port RAM between two masters and routes
// the one-cycle-late read response. Option macro: RAM_ARB_ROUND_ROBIN_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WORD_SIZE_BYTE = 4,
  parameter int SIZE_IN_KB     = 8,
  parameter int ADDR_W         = $clog2(SIZE_IN_KB * 1024 / WORD_SIZE_BYTE) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,

  input  logic                        m0_req_i,
  input  logic [WORD_SIZE_BYTE-1:0]   m0_we_i,
  input  logic [ADDR_W-1:0]           m0_addr_i,
  input  logic [8*WORD_SIZE_BYTE-1:0] m0_wdata_i,
  output logic                        m0_gnt_o,
  output logic                        m0_rvalid_o,
  output logic                        m0_err_o,
  output logic [8*WORD_SIZE_BYTE-1:0] m0_rdata_o,

  input  logic                        m1_req_i,
  input  logic [WORD_SIZE_BYTE-1:0]   m1_we_i,
  input  logic [ADDR_W-1:0]           m1_addr_i,
  input  logic [8*WORD_SIZE_BYTE-1:0] m1_wdata_i,
  output logic                        m1_gnt_o,
  output logic                        m1_rvalid_o,
  output logic                        m1_err_o,
  output logic [8*WORD_SIZE_BYTE-1:0] m1_rdata_o,

  output logic                        mem_en_o,
  output logic [WORD_SIZE_BYTE-1:0]   mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [8*WORD_SIZE_BYTE-1:0] mem_wdata_o,
  input  logic [8*WORD_SIZE_BYTE-1:0] mem_rdata_i
);

  localparam int unsigned    DEPTH   = ram_depth(WORD_SIZE_BYTE, SIZE_IN_KB);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [1:0]                  req;
  logic [1:0]                  gnt;
  logic                        any_gnt;
  logic                        in_range;
  logic [WORD_SIZE_BYTE-1:0]   sel_we;
  logic [ADDR_W-1:0]           sel_addr;
  logic [8*WORD_SIZE_BYTE-1:0] sel_wdata;
  mst_id_e                     ptr;
  rsp_tag_t                    rsp_d, rsp_q;
  logic                        rsp_live;

  // reset blocks all grants combinationally
  assign req = {m1_req_i, m0_req_i} & {2{~rst_i}};

  ram_arb_picker u_picker (
    .req_i (req),
    .ptr_i (ptr),
    .gnt_o (gnt)
  );

`ifdef RAM_ARB_ROUND_ROBIN_EN
  mst_id_e ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = MST_M1;
    end else if (gnt[1]) begin
      ptr_d = MST_M0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= MST_M0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = MST_M0;
`endif

  assign any_gnt  = |gnt;
  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];

  always_comb begin
    sel_we    = m0_we_i;
    sel_addr  = m0_addr_i;
    sel_wdata = m0_wdata_i;
    if (gnt[1]) begin
      sel_we    = m1_we_i;
      sel_addr  = m1_addr_i;
      sel_wdata = m1_wdata_i;
    end
  end

  assign in_range    = ({1'b0, sel_addr} < DEPTH_W);
  assign mem_en_o    = any_gnt & in_range;
  assign mem_we_o    = mem_en_o ? sel_we : '0;
  assign mem_addr_o  = any_gnt ? sel_addr : '0;
  assign mem_wdata_o = any_gnt ? sel_wdata : '0;

  always_comb begin
    rsp_d = '0;
    if (any_gnt) begin
      rsp_d.valid   = 1'b1;
      rsp_d.id      = gnt[1] ? MST_M1 : MST_M0;
      rsp_d.is_read = ~|sel_we;
      rsp_d.err     = ~in_range;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  // a response loaded just before reset must not leak out while reset is high
  assign rsp_live    = rsp_q.valid & ~rst_i;
  assign m0_rvalid_o = rsp_live & (rsp_q.id == MST_M0) & rsp_q.is_read;
  assign m1_rvalid_o = rsp_live & (rsp_q.id == MST_M1) & rsp_q.is_read;
  assign m0_err_o    = rsp_live & (rsp_q.id == MST_M0) & rsp_q.err;
  assign m1_err_o    = rsp_live & (rsp_q.id == MST_M1) & rsp_q.err;
  assign m0_rdata_o  = (m0_rvalid_o & ~m0_err_o) ? mem_rdata_i : '0;
  assign m1_rdata_o  = (m1_rvalid_o & ~m1_err_o) ? mem_rdata_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// tb_ram_port_arbiter : directed self-checking bench with a behavioural RAM
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

  localparam int WB    = 4;
  localparam int KB    = 8;
  localparam int DEPTH = 2048;
  localparam int AW    = 12;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          m0_req_i, m1_req_i;
  logic [WB-1:0] m0_we_i, m1_we_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i;
  logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          mem_en_o;
  logic [WB-1:0] mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;

  logic [DW-1:0] mem [DEPTH];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .WORD_SIZE_BYTE (WB),
    .SIZE_IN_KB     (KB),
    .ADDR_W         (AW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .m0_req_i    (m0_req_i),
    .m0_we_i     (m0_we_i),
    .m0_addr_i   (m0_addr_i),
    .m0_wdata_i  (m0_wdata_i),
    .m0_gnt_o    (m0_gnt_o),
    .m0_rvalid_o (m0_rvalid_o),
    .m0_err_o    (m0_err_o),
    .m0_rdata_o  (m0_rdata_o),
    .m1_req_i    (m1_req_i),
    .m1_we_i     (m1_we_i),
    .m1_addr_i   (m1_addr_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_gnt_o    (m1_gnt_o),
    .m1_rvalid_o (m1_rvalid_o),
    .m1_err_o    (m1_err_o),
    .m1_rdata_o  (m1_rdata_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // single-port RAM, read-first, one-cycle read latency; preloaded during reset
  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      mem[5] <= 32'hDEADBEEF;
      mem[7] <= 32'hAABBCCDD;
    end else if (mem_en_o) begin
      mem_rdata_i <= mem[mem_addr_o[AW-2:0]];
      for (int b = 0; b < WB; b++) begin
        if (mem_we_o[b]) mem[mem_addr_o[AW-2:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic exp_g0;

  initial begin
    rst_i = 1'b1;
    m0_req_i = 1'b1; m0_we_i = '0; m0_addr_i = '0; m0_wdata_i = '0;
    m1_req_i = 1'b0; m1_we_i = '0; m1_addr_i = '0; m1_wdata_i = '0;

    next_cycle();
    @(negedge clk);
    check("rst_m0_gnt",    32'(m0_gnt_o), 0);
    check("rst_mem_en",    32'(mem_en_o), 0);
    check("rst_mem_we",    32'(mem_we_o), 0);
    check("rst_m0_rvalid", 32'(m0_rvalid_o), 0);
    check("rst_m1_rvalid", 32'(m1_rvalid_o), 0);
    check("rst_m0_err",    32'(m0_err_o), 0);
    check("rst_m0_rdata",  m0_rdata_o, 0);

    // m0 reads addr 5
    next_cycle();
    rst_i = 1'b0; m0_req_i = 1'b1; m0_addr_i = 12'd5;
    @(negedge clk);
    check("rd_m0_gnt",   32'(m0_gnt_o), 1);
    check("rd_m1_gnt",   32'(m1_gnt_o), 0);
    check("rd_mem_en",   32'(mem_en_o), 1);
    check("rd_mem_addr", 32'(mem_addr_o), 5);
    next_cycle();
    m0_req_i = 1'b0;
    @(negedge clk);
    check("rd_m0_rvalid", 32'(m0_rvalid_o), 1);
    check("rd_m0_rdata",  m0_rdata_o, 32'hDEADBEEF);
    check("rd_m0_err",    32'(m0_err_o), 0);
    check("rd_m1_rvalid", 32'(m1_rvalid_o), 0);
    check("rd_m1_rdata",  m1_rdata_o, 0);
    check("idle_mem_en",  32'(mem_en_o), 0);

    // m1 partial write to addr 7, then read it back
    next_cycle();
    m1_req_i = 1'b1; m1_we_i = 4'b0011; m1_addr_i = 12'd7; m1_wdata_i = 32'h11223344;
    @(negedge clk);
    check("wr_m1_gnt",    32'(m1_gnt_o), 1);
    check("wr_mem_we",    32'(mem_we_o), 32'h3);
    check("wr_mem_wdata", mem_wdata_o, 32'h11223344);
    next_cycle();
    m1_we_i = 4'b0000;
    @(negedge clk);
    check("wr_m1_rvalid", 32'(m1_rvalid_o), 0);
    check("wr_m1_err",    32'(m1_err_o), 0);
    check("rb_m1_gnt",    32'(m1_gnt_o), 1);
    next_cycle();
    m1_req_i = 1'b0;
    @(negedge clk);
    check("rb_m1_rvalid", 32'(m1_rvalid_o), 1);
    check("rb_m1_rdata",  m1_rdata_o, 32'hAABB3344);
    check("rb_m0_rvalid", 32'(m0_rvalid_o), 0);

    // contention for 6 cycles
    next_cycle();
    m0_req_i = 1'b1; m0_addr_i = 12'd1;
    m1_req_i = 1'b1; m1_addr_i = 12'd2;
    for (int i = 0; i < 6; i++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      exp_g0 = (i % 2 == 0);
`else
      exp_g0 = 1'b1;
`endif
      @(negedge clk);
      check($sformatf("arb%0d_m0_gnt", i), 32'(m0_gnt_o), 32'(exp_g0));
      check($sformatf("arb%0d_m1_gnt", i), 32'(m1_gnt_o), 32'(!exp_g0));
      next_cycle();
    end

    // m0 out-of-range read then out-of-range write
    m1_req_i = 1'b0;
    m0_addr_i = 12'd2048;
    @(negedge clk);
    check("oor_m0_gnt", 32'(m0_gnt_o), 1);
    check("oor_mem_en", 32'(mem_en_o), 0);
    next_cycle();
    m0_addr_i = 12'd3000; m0_we_i = 4'hF; m0_wdata_i = 32'hCAFEF00D;
    @(negedge clk);
    check("oor_m0_rvalid", 32'(m0_rvalid_o), 1);
    check("oor_m0_err",    32'(m0_err_o), 1);
    check("oor_m0_rdata",  m0_rdata_o, 0);
    check("oorw_mem_we",   32'(mem_we_o), 0);
    next_cycle();
    m0_req_i = 1'b0; m0_we_i = '0;
    @(negedge clk);
    check("oorw_m0_err",    32'(m0_err_o), 1);
    check("oorw_m0_rvalid", 32'(m0_rvalid_o), 0);

    // m1 read granted just before reset
    next_cycle();
    m1_req_i = 1'b1; m1_addr_i = 12'd5;
    @(negedge clk);
    check("pre_rst_m1_gnt", 32'(m1_gnt_o), 1);
    next_cycle();
    rst_i = 1'b1; m0_req_i = 1'b1; m0_addr_i = 12'd1;
    @(negedge clk);
    check("inrst_m1_rvalid", 32'(m1_rvalid_o), 0);
    check("inrst_m1_rdata",  m1_rdata_o, 0);
    check("inrst_m1_err",    32'(m1_err_o), 0);
    check("inrst_gnt",       32'({m1_gnt_o, m0_gnt_o}), 0);
    check("inrst_mem_en",    32'(mem_en_o), 0);
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_m0_gnt", 32'(m0_gnt_o), 1);
    check("post_rst_m1_gnt", 32'(m1_gnt_o), 0);
    next_cycle();
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
